// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared constants and helpers for the pipelined add/subtract unit.
// Revision : 1.0  - initial release
// ============================================================================
package adder_pkg;

    // Operation select encoding for the Sub input
    localparam logic ADD_MODE = 1'b0;
    localparam logic SUB_MODE = 1'b1;

    // Width of the slice each pipeline stage adds
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// Module   : adder_chunk
// Purpose  : Combinational CHUNK-bit adder slice with carry in and carry out.
// Revision : 1.0  - initial release
// ============================================================================
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] total;

    // Zero-extend by one bit so the slice carry lands in the top bit
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

    assign s    = total[CHUNK-1:0];
    assign cout = total[CHUNK];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : Parametrised pipelined add/subtract unit with signed overflow
//            flag and valid/ready handshake on both sides. Each stage adds
//            one CHUNK-bit slice; the carry ripples through the stage
//            registers while the upper operand bits travel with the beat.
// Revision : 1.0  - initial release
// ============================================================================
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             C_out,
    output logic             OVF
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    // Stage registers: operands (B already conditioned for subtract),
    // partial sum, carry out of the slice just added, and a valid bit.
    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0][WIDTH-1:0]  a_q;
    logic [STAGES-1:0][WIDTH-1:0]  b_q;
    logic [STAGES-1:0][WIDTH-1:0]  sum_q;
    logic [STAGES-1:0]             carry_q;

    // What each stage would load: stage 0 from the ports, others from k-1
    logic [STAGES-1:0]             src_valid;
    logic [STAGES-1:0][WIDTH-1:0]  src_a;
    logic [STAGES-1:0][WIDTH-1:0]  src_b;
    logic [STAGES-1:0][WIDTH-1:0]  src_sum;
    logic [STAGES-1:0]             src_cin;

    logic [STAGES-1:0][CHUNK-1:0]  ch_s;
    logic [STAGES-1:0]             ch_cout;
    logic [STAGES-1:0][WIDTH-1:0]  nxt_sum;

    // load_ext[k]: stage k may capture this cycle; load_ext[STAGES] is the
    // consumer's ready, so the chain runs combinationally from out_ready.
    logic [STAGES:0]               load_ext;
    logic [STAGES-1:0]             advance;

    // Ready chain: a stage advances when it holds data and the next stage
    // (or the consumer) takes it; an empty stage always accepts.
    always_comb begin
        load_ext         = '0;
        advance          = '0;
        load_ext[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            advance[k]  = valid_q[k] & load_ext[k+1];
            load_ext[k] = ~valid_q[k] | advance[k];
        end
    end

    assign in_ready = load_ext[0];

    // Source selection: subtract becomes A + ~B + ~C_in at the entry stage
    always_comb begin
        src_valid = '0;
        src_a     = '0;
        src_b     = '0;
        src_sum   = '0;
        src_cin   = '0;

        src_valid[0] = in_valid;
        src_a[0]     = A;
        src_b[0]     = (Sub == SUB_MODE) ? ~B : B;
        src_cin[0]   = (Sub == SUB_MODE) ? ~C_in : C_in;
        src_sum[0]   = '0;

        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_sum[k]   = sum_q[k-1];
            src_cin[k]   = carry_q[k-1];
        end
    end

    // One slice adder per stage, each working on its own CHUNK of the word
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (src_a[k][k*CHUNK +: CHUNK]),
            .b    (src_b[k][k*CHUNK +: CHUNK]),
            .cin  (src_cin[k]),
            .s    (ch_s[k]),
            .cout (ch_cout[k])
        );
    end

    // Merge each stage's freshly added slice into the travelling partial sum
    always_comb begin
        nxt_sum = src_sum;
        for (int k = 0; k < STAGES; k++) begin
            nxt_sum[k][k*CHUNK +: CHUNK] = ch_s[k];
        end
    end

    // Stage registers: payload only changes when a valid beat is captured,
    // so a stalled last stage keeps SUM/C_out/OVF stable.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load_ext[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        a_q[k]     <= src_a[k];
                        b_q[k]     <= src_b[k];
                        sum_q[k]   <= nxt_sum[k];
                        carry_q[k] <= ch_cout[k];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign SUM       = sum_q[LAST];
    assign C_out     = carry_q[LAST];
    // Signed overflow: operands agree in sign but the result does not
    assign OVF       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                       (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
`default_nettype wire
